// File: rtl/multiport_regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;

    // Storage is either being swept to zero after reset, or in normal service.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_ZERO_REG = 1;

    // LSB position of read port 'port' inside a packed multi-port vector.
    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/multiport_regfile_if.sv
// Decode/writeback-facing bus of the register file: reads, two write ports, issue.
interface multiport_regfile_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) ();

    logic                       ready;
    logic [NUM_RD*ADDR_W-1:0]   rd_addr;
    logic [NUM_RD*DATA_W-1:0]   rd_data;
    logic [NUM_RD-1:0]          rd_busy;
    logic                       wr0_en;
    logic [ADDR_W-1:0]          wr0_addr;
    logic [DATA_W-1:0]          wr0_data;
    logic                       wr1_en;
    logic [ADDR_W-1:0]          wr1_addr;
    logic [DATA_W-1:0]          wr1_data;
    logic                       iss_en;
    logic [ADDR_W-1:0]          iss_addr;

    // Pipeline side: drives addresses, writes and issues.
    modport master (
        input  ready, rd_data, rd_busy,
        output rd_addr, wr0_en, wr0_addr, wr0_data,
               wr1_en, wr1_addr, wr1_data, iss_en, iss_addr
    );

    // Register file side.
    modport slave (
        output ready, rd_data, rd_busy,
        input  rd_addr, wr0_en, wr0_addr, wr0_data,
               wr1_en, wr1_addr, wr1_data, iss_en, iss_addr
    );

endinterface

// File: rtl/multiport_regfile_scoreboard.sv
// One pending bit per entry: set by issue, cleared by either write port.
// An issue wins over a write to the same entry in the same cycle, since the
// newly issued producer has not yet written back.
module regfile_scoreboard #(
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    i_clr_all,
    input  logic                    i_iss_en,
    input  logic [ADDR_W-1:0]       i_iss_addr,
    input  logic                    i_clr0_en,
    input  logic [ADDR_W-1:0]       i_clr0_addr,
    input  logic                    i_clr1_en,
    input  logic [ADDR_W-1:0]       i_clr1_addr,
    input  logic                    i_zero_mask,
    output logic [(1<<ADDR_W)-1:0]  o_pending
);

    localparam int DEPTH = 1 << ADDR_W;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_bit
            logic r_pend;
            logic w_set;
            logic w_clr;
            logic w_masked;

            assign w_set    = i_iss_en && (i_iss_addr == ADDR_W'(gi));
            assign w_clr    = (i_clr0_en && (i_clr0_addr == ADDR_W'(gi))) ||
                              (i_clr1_en && (i_clr1_addr == ADDR_W'(gi)));
            assign w_masked = i_zero_mask && (gi == 0);

            // Track whether this entry is still waiting for its writeback.
            always_ff @(posedge clk) begin
                if (i_clr_all || w_masked) begin
                    r_pend <= 1'b0;
                end else if (w_set) begin
                    r_pend <= 1'b1;
                end else if (w_clr) begin
                    r_pend <= 1'b0;
                end
            end

            assign o_pending[gi] = r_pend;
        end
    endgenerate

endmodule

// File: rtl/multiport_regfile.sv
// Parametrised register file: NUM_RD combinational read ports with write-first
// bypass, two write ports (port 1 has priority), optional hardwired zero entry,
// pending-write scoreboard and a one-entry-per-cycle clear sweep after reset.
module multiport_regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = DEF_ZERO_REG
) (
    input  logic                 clk,
    input  logic                 reset,
    multiport_regfile_if.slave   bus
);

    localparam int DEPTH = 1 << ADDR_W;

    rf_state_e              r_state;
    logic [ADDR_W-1:0]      r_clear_idx;
    logic                   r_ready;
    logic [DATA_W-1:0]      r_mem [DEPTH];

    logic                   w_run;
    logic                   w_wr0_ok;
    logic                   w_wr1_ok;
    logic                   w_iss_ok;
    logic                   w_clr_we;
    logic [DEPTH-1:0]       w_pending;
    logic [NUM_RD*DATA_W-1:0] w_rd_data;
    logic [NUM_RD-1:0]      w_rd_busy;

    // Entry 0 is hardwired to zero when ZERO_REG is set.
    function automatic logic f_is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign w_run    = (r_state == RUN);
    // Qualified write/issue requests; these also drive bypass and busy masking.
    assign w_wr0_ok = w_run && bus.wr0_en && !f_is_zero(bus.wr0_addr);
    assign w_wr1_ok = w_run && bus.wr1_en && !f_is_zero(bus.wr1_addr);
    assign w_iss_ok = w_run && bus.iss_en && !f_is_zero(bus.iss_addr);
    assign w_clr_we = (r_state == CLEAR) && !reset;

    // Clear/run controller: sweep every entry once after reset, then serve.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= CLEAR;
            r_clear_idx <= '0;
            r_ready     <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_clear_idx <= r_clear_idx + ADDR_W'(1);
                    if (r_clear_idx == ADDR_W'(DEPTH - 1)) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                    end
                end
                RUN: begin
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= CLEAR;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage writes: clear sweep, else port 0 then port 1 so port 1 wins a tie.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clear_idx] <= '0;
        end else begin
            if (w_wr0_ok && !reset) begin
                r_mem[bus.wr0_addr] <= bus.wr0_data;
            end
            if (w_wr1_ok && !reset) begin
                r_mem[bus.wr1_addr] <= bus.wr1_data;
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk         (clk),
        .i_clr_all   (reset || !w_run),
        .i_iss_en    (w_iss_ok),
        .i_iss_addr  (bus.iss_addr),
        .i_clr0_en   (w_wr0_ok),
        .i_clr0_addr (bus.wr0_addr),
        .i_clr1_en   (w_wr1_ok),
        .i_clr1_addr (bus.wr1_addr),
        .i_zero_mask (ZERO_REG != 0),
        .o_pending   (w_pending)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            logic              w_hit0;
            logic              w_hit1;
            logic              w_zero;
            logic [DATA_W-1:0] w_data;

            assign w_addr = bus.rd_addr[port_lsb(gi, ADDR_W) +: ADDR_W];
            assign w_hit0 = w_wr0_ok && (bus.wr0_addr == w_addr);
            assign w_hit1 = w_wr1_ok && (bus.wr1_addr == w_addr);
            assign w_zero = f_is_zero(w_addr);

            // Read mux: storage, overridden by same-cycle writes (port 1 last).
            always_comb begin
                w_data = r_mem[w_addr];
                if (w_hit0) begin
                    w_data = bus.wr0_data;
                end
                if (w_hit1) begin
                    w_data = bus.wr1_data;
                end
                if (!w_run || w_zero) begin
                    w_data = '0;
                end
            end

            assign w_rd_data[port_lsb(gi, DATA_W) +: DATA_W] = w_data;
            assign w_rd_busy[gi] = w_run && !w_zero && w_pending[w_addr] &&
                                   !w_hit0 && !w_hit1;
        end
    endgenerate

    assign bus.rd_data = w_rd_data;
    assign bus.rd_busy = w_rd_busy;
    assign bus.ready   = r_ready;

endmodule

// File: tb/tb_multiport_regfile.sv
// Self-checking bench for multiport_regfile (32x32, 2 read ports, zero reg).
module tb_multiport_regfile;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multiport_regfile_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

    multiport_regfile #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_RD   (NR),
        .ZERO_REG (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: register contents and outstanding-writeback flags.
    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_pend [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.wr0_en = 1'b0;
        bus.wr1_en = 1'b0;
        bus.iss_en = 1'b0;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        bus.rd_addr[p*AW +: AW] = a;
    endtask

    task automatic model_zero();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (bus.wr1_en && bus.wr1_addr == a) return bus.wr1_data;
        if (bus.wr0_en && bus.wr0_addr == a) return bus.wr0_data;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (bus.wr1_en && bus.wr1_addr == a) return 1'b0;
        if (bus.wr0_en && bus.wr0_addr == a) return 1'b0;
        return m_pend[a];
    endfunction

    // Compare every read port against the model for the current inputs.
    task automatic check_ports(input string tag);
        #2;
        for (int p = 0; p < NR; p++) begin
            logic [AW-1:0] a;
            a = bus.rd_addr[p*AW +: AW];
            chk($sformatf("%s_data%0d_a%0d", tag, p, a), bus.rd_data[p*DW +: DW], exp_data(a));
            chk($sformatf("%s_busy%0d_a%0d", tag, p, a), 32'(bus.rd_busy[p]), 32'(exp_busy(a)));
        end
    endtask

    // Apply this cycle's writes/issue to the model, then advance one edge.
    task automatic tick();
        if (bus.wr0_en && bus.wr0_addr != 0) begin
            m_mem[bus.wr0_addr]  = bus.wr0_data;
            m_pend[bus.wr0_addr] = 1'b0;
        end
        if (bus.wr1_en && bus.wr1_addr != 0) begin
            m_mem[bus.wr1_addr]  = bus.wr1_data;
            m_pend[bus.wr1_addr] = 1'b0;
        end
        if (bus.iss_en && bus.iss_addr != 0) begin
            m_pend[bus.iss_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    // Called just after the edge that sampled reset; counts cycles until ready,
    // throwing ignored writes/issues at the DUT and checking masked reads.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (bus.ready !== 1'b1 && n < 200) begin
            bus.wr0_en   = 1'($urandom_range(0, 1));
            bus.wr0_addr = AW'($urandom_range(0, 31));
            bus.wr0_data = $urandom;
            bus.wr1_en   = 1'($urandom_range(0, 1));
            bus.wr1_addr = AW'($urandom_range(0, 31));
            bus.wr1_data = $urandom;
            bus.iss_en   = 1'($urandom_range(0, 1));
            bus.iss_addr = AW'($urandom_range(0, 31));
            set_rd(0, AW'($urandom_range(0, 31)));
            set_rd(1, bus.wr1_addr);
            #2;
            chk($sformatf("%s_clr_data0", tag), bus.rd_data[0 +: DW], 32'h0);
            chk($sformatf("%s_clr_data1", tag), bus.rd_data[DW +: DW], 32'h0);
            chk($sformatf("%s_clr_busy", tag), 32'(bus.rd_busy), 32'h0);
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("%s_clear_cycles", tag), 32'(n), 32'd32);
        idle();
        model_zero();
    endtask

    // Every address via both ports must match the model with no writes active.
    task automatic sweep(input string tag);
        idle();
        for (int a = 0; a < DEPTH; a++) begin
            set_rd(0, AW'(a));
            set_rd(1, AW'((a + 7) % DEPTH));
            check_ports(tag);
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.rd_addr  = '0;
        bus.wr0_addr = '0;
        bus.wr0_data = '0;
        bus.wr1_addr = '0;
        bus.wr1_data = '0;
        bus.iss_addr = '0;
        idle();
        model_zero();

        // Power-up reset, then the 32-cycle clear sweep.
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_ready", 32'(bus.ready), 32'h0);
        chk("rst_data", bus.rd_data[0 +: DW], 32'h0);
        chk("rst_busy", 32'(bus.rd_busy), 32'h0);
        wait_ready("boot");
        sweep("boot_sweep");

        // Same-cycle bypass through read port 1, then from storage.
        idle();
        set_rd(0, 5'd4);
        set_rd(1, 5'd5);
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd5; bus.wr0_data = 32'hDEADBEEF;
        #2;
        chk("byp5", bus.rd_data[DW +: DW], 32'hDEADBEEF);
        tick();
        idle();
        #2;
        chk("st5", bus.rd_data[DW +: DW], 32'hDEADBEEF);

        // Both write ports hit the same entry: port 1 data wins.
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd7; bus.wr0_data = 32'h11111111;
        bus.wr1_en = 1'b1; bus.wr1_addr = 5'd7; bus.wr1_data = 32'h22222222;
        set_rd(0, 5'd7);
        #2;
        chk("byp7_prio", bus.rd_data[0 +: DW], 32'h22222222);
        tick();
        idle();
        #2;
        chk("st7_prio", bus.rd_data[0 +: DW], 32'h22222222);

        // Issue, writeback, and issue+writeback together on entry 3.
        bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
        tick();
        idle();
        set_rd(0, 5'd3);
        #2;
        chk("busy3_set", 32'(bus.rd_busy[0]), 32'h1);
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd3; bus.wr0_data = 32'h5;
        #1;
        chk("busy3_wb", 32'(bus.rd_busy[0]), 32'h0);
        chk("data3_wb", bus.rd_data[0 +: DW], 32'h5);
        tick();
        idle();
        #2;
        chk("busy3_after", 32'(bus.rd_busy[0]), 32'h0);
        chk("data3_after", bus.rd_data[0 +: DW], 32'h5);
        bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd3; bus.wr0_data = 32'h9;
        tick();
        idle();
        #2;
        chk("busy3_iss_wr", 32'(bus.rd_busy[0]), 32'h1);
        chk("data3_iss_wr", bus.rd_data[0 +: DW], 32'h9);

        // Zero register: writes and issues to entry 0 are dropped.
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd0; bus.wr0_data = 32'hFFFFFFFF;
        bus.wr1_en = 1'b1; bus.wr1_addr = 5'd0; bus.wr1_data = 32'hFFFFFFFF;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd0;
        set_rd(0, 5'd0);
        set_rd(1, 5'd0);
        #2;
        chk("zero_byp", bus.rd_data[0 +: DW], 32'h0);
        tick();
        idle();
        #2;
        chk("zero_data", bus.rd_data[DW +: DW], 32'h0);
        chk("zero_busy", 32'(bus.rd_busy), 32'h0);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bus.wr0_en   = 1'($urandom_range(0, 1));
            bus.wr0_addr = AW'($urandom_range(0, 31));
            bus.wr0_data = $urandom;
            bus.wr1_en   = ($urandom_range(0, 2) == 0);
            bus.wr1_addr = ($urandom_range(0, 2) == 0) ? bus.wr0_addr : AW'($urandom_range(0, 31));
            bus.wr1_data = $urandom;
            bus.iss_en   = 1'($urandom_range(0, 1));
            bus.iss_addr = ($urandom_range(0, 3) == 0) ? bus.wr0_addr : AW'($urandom_range(0, 31));
            for (int p = 0; p < NR; p++) begin
                case ($urandom_range(0, 2))
                    0:       set_rd(p, bus.wr0_addr);
                    1:       set_rd(p, bus.wr1_addr);
                    default: set_rd(p, AW'($urandom_range(0, 31)));
                endcase
            end
            check_ports("rnd");
            chk("rnd_ready", 32'(bus.ready), 32'h1);
            tick();
        end
        idle();
        sweep("rnd_sweep");

        // Populate, leave some pending, then reset in RUN and again at clear_idx=10.
        for (int a = 1; a < DEPTH; a++) begin
            bus.wr0_en = 1'b1; bus.wr0_addr = AW'(a); bus.wr0_data = 32'hA5A50000 | 32'(a);
            bus.iss_en = 1'b1; bus.iss_addr = AW'((a * 3) % DEPTH);
            tick();
        end
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midclr_ready", 32'(bus.ready), 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_ready("midclr");
        chk("midclr_ready_hi", 32'(bus.ready), 32'h1);
        sweep("midclr_sweep");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
